hazard_stall_flush_unit: RTL

- Pipeline hazard controller that drives the write-enable and flush inputs of the IF/ID register, the PC write enable, and the ID/EX control bubble.
- Detects load-use hazards and taken branches, and freezes the whole pipeline while data memory is busy.
- Defers a branch flush that arrives during a freeze until the pipeline is released.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_stall_flush_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/hazard_stall_flush_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-busy freeze with deferred flush.
// Control outputs are combinational from state and inputs; state and saturating counters update on the next edge.
module hazard_stall_flush_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] IF_ID_rs1,
    input  logic [REG_W-1:0] IF_ID_rs2,
    input  logic [REG_W-1:0] ID_EX_rd,
    input  logic             ID_EX_MemRead,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             Flush,
    output logic             ID_EX_Bubble,
    output logic             Pipe_Freeze,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   flush_pending;
    logic   flush_pending_nxt;
    logic   load_use;
    logic   br;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ID_EX_MemRead && (ID_EX_rd != '0) &&
                      ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
    assign br = branch_taken || flush_pending;

    always_comb begin
        PC_Write          = 1'b1;
        IF_ID_Write       = 1'b1;
        Flush             = 1'b0;
        ID_EX_Bubble      = 1'b0;
        Pipe_Freeze       = 1'b0;
        state_nxt         = state;
        flush_pending_nxt = flush_pending;

        if (reset) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            Flush        = 1'b1;
            ID_EX_Bubble = 1'b1;
            state_nxt         = RUN;
            flush_pending_nxt = 1'b0;
        end else if (mem_busy) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Freeze = 1'b1;
            state_nxt   = MEM_WAIT;
            // Branches seen during a freeze accumulate so the flush fires once on release.
            flush_pending_nxt = (state == MEM_WAIT) ? (flush_pending || branch_taken)
                                                    : branch_taken;
        end else if (br) begin
            Flush             = 1'b1;
            ID_EX_Bubble      = 1'b1;
            state_nxt         = RUN;
            flush_pending_nxt = 1'b0;
        end else if (load_use && (state != LU_STALL)) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            state_nxt    = LU_STALL;
        end else begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            flush_pending <= 1'b0;
            stall_count   <= '0;
            flush_count   <= '0;
        end else begin
            state         <= state_nxt;
            flush_pending <= flush_pending_nxt;
            if (!PC_Write && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
            if (Flush && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule
